// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the ARM data-processing sequencer: FSM states,
// opcode and condition-field encodings, and opcode classification helpers.
package dp_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DECODE    = 2'd1,
      EXECUTE   = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Compare/test opcodes only set flags and never write Rd.
   function automatic logic is_test_op(input logic [3:0] op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

   function automatic logic is_arith_op(input logic [3:0] op);
      return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against {N,Z,C,V}.
module cond_check
   import dp_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[3];
   assign z = nzcv[2];
   assign c = nzcv[1];
   assign v = nzcv[0];

   // NV is never reached for legal instructions; treat it as a failed condition.
   always_comb begin
      pass = 1'b0;
      unique case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for ARM register-form data-processing
// instructions: decode, condition check, register-file and flag control.
module dp_sequencer
   import dp_ctrl_pkg::*;
#(
   parameter int         REG_ADDR_W = 5,
   parameter logic [3:0] CPSR_RST   = 4'b0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic                  zero_flag,
   input  logic                  carry_flag,
   input  logic                  overflow_flag,
   input  logic                  negative_flag,
   output logic [REG_ADDR_W-1:0] read_reg_num1,
   output logic [REG_ADDR_W-1:0] read_reg_num2,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [3:0]            alu_control,
   output logic                  regwrite,
   output logic [3:0]            nzcv,
   output logic                  retire,
   output logic                  skipped,
   output logic                  undef
);

   state_t      state, next_state;
   logic [31:0] instr_q;
   logic [3:0]  cond, opcode, rn, rd, rm;
   logic        s_bit, legal, cond_pass, accept, flag_update;

   assign cond   = instr_q[31:28];
   assign opcode = instr_q[24:21];
   assign s_bit  = instr_q[20];
   assign rn     = instr_q[19:16];
   assign rd     = instr_q[15:12];
   assign rm     = instr_q[3:0];

   // Only register-form, unshifted data processing; writing the PC is rejected.
   assign legal = (instr_q[27:25] == 3'b000) && (instr_q[11:4] == 8'h00) &&
                  (cond != COND_NV) && !(!is_test_op(opcode) && (rd == 4'hF));

   cond_check u_cond_check (
      .cond (cond),
      .nzcv (nzcv),
      .pass (cond_pass)
   );

   assign instr_ready = (state == IDLE);
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      next_state    = state;
      read_reg_num1 = '0;
      read_reg_num2 = '0;
      write_reg     = '0;
      alu_control   = 4'h0;
      regwrite      = 1'b0;
      retire        = 1'b0;
      skipped       = 1'b0;
      undef         = 1'b0;
      flag_update   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) next_state = DECODE;
         end
         DECODE: begin
            if (!legal) begin
               undef      = 1'b1;
               next_state = IDLE;
            end else if (!cond_pass) begin
               retire     = 1'b1;
               skipped    = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = EXECUTE;
            end
         end
         EXECUTE: begin
            read_reg_num1 = REG_ADDR_W'(rn);
            read_reg_num2 = REG_ADDR_W'(rm);
            write_reg     = REG_ADDR_W'(rd);
            alu_control   = opcode;
            next_state    = WRITEBACK;
         end
         WRITEBACK: begin
            read_reg_num1 = REG_ADDR_W'(rn);
            read_reg_num2 = REG_ADDR_W'(rm);
            write_reg     = REG_ADDR_W'(rd);
            alu_control   = opcode;
            // A reset landing on this edge must not let the register file commit.
            regwrite      = !is_test_op(opcode) && !reset;
            retire        = 1'b1;
            flag_update   = s_bit;
            next_state    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         instr_q <= '0;
         nzcv    <= CPSR_RST;
      end else begin
         state <= next_state;
         if (accept) instr_q <= instr;
         if (flag_update) begin
            if (is_arith_op(opcode))
               nzcv <= {negative_flag, zero_flag, carry_flag, overflow_flag};
            else
               nzcv <= {negative_flag, zero_flag, nzcv[1:0]};
         end
      end
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed, table-driven bench for dp_sequencer with hand-computed expectations
// plus a hand-written reset-during-writeback sequence.
module tb_dp_sequencer;

   localparam int         REG_ADDR_W = 5;
   localparam logic [3:0] CPSR_RST   = 4'b0000;

   logic                  clock;
   logic                  reset;
   logic [31:0]           instr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  zero_flag, carry_flag, overflow_flag, negative_flag;
   logic [REG_ADDR_W-1:0] read_reg_num1, read_reg_num2, write_reg;
   logic [3:0]            alu_control;
   logic                  regwrite;
   logic [3:0]            nzcv;
   logic                  retire, skipped, undef;

   dp_sequencer #(
      .REG_ADDR_W (REG_ADDR_W),
      .CPSR_RST   (CPSR_RST)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .negative_flag (negative_flag),
      .read_reg_num1 (read_reg_num1),
      .read_reg_num2 (read_reg_num2),
      .write_reg     (write_reg),
      .alu_control   (alu_control),
      .regwrite      (regwrite),
      .nzcv          (nzcv),
      .retire        (retire),
      .skipped       (skipped),
      .undef         (undef)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef enum int {K_PASS, K_SKIP, K_UNDEF} kind_t;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  flags;
      kind_t       kind;
      logic        regwrite;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [3:0]  rd;
      logic [3:0]  alu;
      logic [3:0]  nzcv;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
   task automatic applyStimulus(input vec_t v, input int idx);
      int waited = 0;
      while (!instr_ready && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      checkOutput($sformatf("v%0d ready", idx), 32'(instr_ready), 32'd1);
      instr       = v.instr;
      instr_valid = 1'b1;
      {negative_flag, zero_flag, carry_flag, overflow_flag} = v.flags;
      @(posedge clock);
      #1;
      // Garbage with valid held high must be ignored while busy.
      if (v.kind == K_PASS) instr = 32'hFFFF_FFFF;
      else instr_valid = 1'b0;
      @(negedge clock);
      checkOutput($sformatf("v%0d dec ready", idx), 32'(instr_ready), 32'd0);
      checkOutput($sformatf("v%0d dec undef", idx), 32'(undef), 32'(v.kind == K_UNDEF));
      checkOutput($sformatf("v%0d dec retire", idx), 32'(retire), 32'(v.kind == K_SKIP));
      checkOutput($sformatf("v%0d dec skipped", idx), 32'(skipped), 32'(v.kind == K_SKIP));
      checkOutput($sformatf("v%0d dec regwrite", idx), 32'(regwrite), 32'd0);
      checkOutput($sformatf("v%0d dec rd", idx), 32'(write_reg), 32'd0);
      if (v.kind == K_PASS) begin
         @(negedge clock);
         checkOutput($sformatf("v%0d ex regwrite", idx), 32'(regwrite), 32'd0);
         checkOutput($sformatf("v%0d ex retire", idx), 32'(retire), 32'd0);
         checkOutput($sformatf("v%0d ex rn", idx), 32'(read_reg_num1), 32'(v.rn));
         checkOutput($sformatf("v%0d ex rm", idx), 32'(read_reg_num2), 32'(v.rm));
         checkOutput($sformatf("v%0d ex rd", idx), 32'(write_reg), 32'(v.rd));
         checkOutput($sformatf("v%0d ex alu", idx), 32'(alu_control), 32'(v.alu));
         @(posedge clock);
         #1;
         instr_valid = 1'b0;
         @(negedge clock);
         checkOutput($sformatf("v%0d wb regwrite", idx), 32'(regwrite), 32'(v.regwrite));
         checkOutput($sformatf("v%0d wb retire", idx), 32'(retire), 32'd1);
         checkOutput($sformatf("v%0d wb skipped", idx), 32'(skipped), 32'd0);
         checkOutput($sformatf("v%0d wb undef", idx), 32'(undef), 32'd0);
         checkOutput($sformatf("v%0d wb rn", idx), 32'(read_reg_num1), 32'(v.rn));
         checkOutput($sformatf("v%0d wb rm", idx), 32'(read_reg_num2), 32'(v.rm));
         checkOutput($sformatf("v%0d wb rd", idx), 32'(write_reg), 32'(v.rd));
         checkOutput($sformatf("v%0d wb alu", idx), 32'(alu_control), 32'(v.alu));
      end
      @(negedge clock);
      checkOutput($sformatf("v%0d idle ready", idx), 32'(instr_ready), 32'd1);
      checkOutput($sformatf("v%0d idle retire", idx), 32'(retire), 32'd0);
      checkOutput($sformatf("v%0d nzcv", idx), 32'(nzcv), 32'(v.nzcv));
   endtask

   initial begin
      // Fields: instr, flags{N,Z,C,V}, kind, regwrite, rn, rm, rd, alu, nzcv after
      vecs[0]  = '{32'hE0921003, 4'b0110, K_PASS,  1'b1, 4'd2, 4'd3, 4'd1,  4'h4, 4'b0110};
      vecs[1]  = '{32'hE1540005, 4'b1000, K_PASS,  1'b0, 4'd4, 4'd5, 4'd0,  4'hA, 4'b1000};
      vecs[2]  = '{32'h01A00007, 4'b0000, K_SKIP,  1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b1000};
      vecs[3]  = '{32'hE2811001, 4'b1111, K_UNDEF, 1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b1000};
      vecs[4]  = '{32'hE081F002, 4'b1111, K_UNDEF, 1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b1000};
      vecs[5]  = '{32'hE1540005, 4'b1111, K_PASS,  1'b0, 4'd4, 4'd5, 4'd0,  4'hA, 4'b1111};
      vecs[6]  = '{32'h01A00007, 4'b0000, K_PASS,  1'b1, 4'd0, 4'd7, 4'd0,  4'hD, 4'b1111};
      vecs[7]  = '{32'hE0121003, 4'b0000, K_PASS,  1'b1, 4'd2, 4'd3, 4'd1,  4'h0, 4'b0011};
      vecs[8]  = '{32'hE1540005, 4'b1100, K_PASS,  1'b0, 4'd4, 4'd5, 4'd0,  4'hA, 4'b1100};
      vecs[9]  = '{32'hE0121003, 4'b0000, K_PASS,  1'b1, 4'd2, 4'd3, 4'd1,  4'h0, 4'b0000};
      vecs[10] = '{32'hC1A00007, 4'b0000, K_PASS,  1'b1, 4'd0, 4'd7, 4'd0,  4'hD, 4'b0000};
      vecs[11] = '{32'hB1A00007, 4'b0000, K_SKIP,  1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b0000};
      vecs[12] = '{32'hF1A00007, 4'b0000, K_UNDEF, 1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b0000};
      vecs[13] = '{32'hE0821013, 4'b0000, K_UNDEF, 1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b0000};
      vecs[14] = '{32'hE112F003, 4'b1011, K_PASS,  1'b0, 4'd2, 4'd3, 4'd15, 4'h8, 4'b1000};
      vecs[15] = '{32'h81A00007, 4'b0000, K_SKIP,  1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b1000};
      vecs[16] = '{32'hE0921003, 4'b1001, K_PASS,  1'b1, 4'd2, 4'd3, 4'd1,  4'h4, 4'b1001};
      vecs[17] = '{32'h61A00007, 4'b0000, K_PASS,  1'b1, 4'd0, 4'd7, 4'd0,  4'hD, 4'b1001};
      vecs[18] = '{32'h91A00007, 4'b0000, K_PASS,  1'b1, 4'd0, 4'd7, 4'd0,  4'hD, 4'b1001};
      vecs[19] = '{32'hA1A00007, 4'b0000, K_PASS,  1'b1, 4'd0, 4'd7, 4'd0,  4'hD, 4'b1001};
      vecs[20] = '{32'h51A00007, 4'b0000, K_SKIP,  1'b0, 4'd0, 4'd0, 4'd0,  4'h0, 4'b1001};

      reset       = 1'b1;
      instr       = 32'h0;
      instr_valid = 1'b0;
      {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b0000;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset ready", 32'(instr_ready), 32'd1);
      checkOutput("reset nzcv", 32'(nzcv), 32'(CPSR_RST));
      checkOutput("reset regwrite", 32'(regwrite), 32'd0);
      checkOutput("reset retire", 32'(retire), 32'd0);
      checkOutput("reset skipped", 32'(skipped), 32'd0);
      checkOutput("reset undef", 32'(undef), 32'd0);
      checkOutput("reset write_reg", 32'(write_reg), 32'd0);

      for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

      // Reset landing in WRITEBACK: write and flag update both discarded.
      instr       = 32'hE0921003;
      instr_valid = 1'b1;
      {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b1111;
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rstwb regwrite", 32'(regwrite), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rstwb ready", 32'(instr_ready), 32'd1);
      checkOutput("rstwb nzcv", 32'(nzcv), 32'(CPSR_RST));
      checkOutput("rstwb retire", 32'(retire), 32'd0);
      checkOutput("rstwb regwrite idle", 32'(regwrite), 32'd0);
      checkOutput("rstwb rn", 32'(read_reg_num1), 32'd0);

      applyStimulus('{32'hE0921003, 4'b0110, K_PASS, 1'b1, 4'd2, 4'd3, 4'd1, 4'h4, 4'b0110}, 99);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
